_pending_latch: RTL
===================

# _pending_latch

Sticky per-bit event capture stage sitting directly upstream of the `_or` reduction. It detects rising edges on `INPUT_WIDTH` raw event lines and holds each as a pending flag until it is explicitly cleared. It drives `pendingData` straight into `_or`'s `inputData`, so the `_or` output becomes the "any event pending" summary. A per-bit mask and a per-bit overflow indication are provided for software-style acknowledge flows.

## Interface
Parameters:
- `INPUT_WIDTH`, 1: number of event lines, ≥1; must match the downstream `_or` instance.

Ports:
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; one clock domain, async assert.
- `pendingData`  out  INPUT_WIDTH  sticky pending flags; connects to `_or.inputData`.
- `overflowData`  out  INPUT_WIDTH  sticky flag: an edge arrived while that bit was already pending.
- `DigitSupply`  in  2  logic level supply: `[0]` = low level, `[1]` = high level. Every constant and reset value is taken from it. Normal operation drives 2'b10.
- `eventData`  in  INPUT_WIDTH  raw event levels; a 0→1 transition is one event.
- `maskData`  in  INPUT_WIDTH  1 = ignore new events on that bit.
- `clearData`  in  INPUT_WIDTH  1 = clear pending and overflow of that bit this cycle.

## Operation
- Per bit i, registers: `prev[i]` (last sampled event level), `pend[i]`, `ovf[i]`.
- `rise[i] = ev[i] & ~prev[i]`, where `ev` is `eventData`, or the synchronizer output when `PENDING_LATCH_SYNC_EN` is defined.
- `prev[i]` loads `ev[i]` every cycle, regardless of mask or clear.
- Next pending value: `pend[i] <= (rise[i] & ~maskData[i]) | (pend[i] & ~clearData[i])`.
  - Set wins over a same-cycle clear: the old event is acknowledged and the new event is retained.
- Next overflow value: `ovf[i] <= (rise[i] & ~maskData[i] & pend[i] & ~clearData[i]) | (ovf[i] & ~clearData[i])`.
- Mask behaviour:
  - Masking blocks new sets only. An already pending bit stays pending until it is cleared.
  - Because `prev` keeps tracking the line, unmasking while the line is held high creates no event.
- `clearData` on a bit that is not pending has no effect.
- There is no per-bit FSM beyond the pend/ovf pair. Each bit is independent; there is no cross-bit interaction.
- `pendingData = pend`, `overflowData = ovf`.

## Timing
- Reset (async assert, synchronous release at the next `Clock` edge):
  - `pend`, `ovf`, `prev` and the synchronizer flops all load `DigitSupply[0]`.
  - `pendingData` and `overflowData` read 0 immediately, without waiting for a clock.
- Line held high through reset release: `prev` = 0, so the first post-reset edge sees a rise. This counts as one event (intended: no event is lost across reset).
- Latency without sync: `eventData` goes 1 before edge N → `pendingData` is 1 after edge N (1 cycle).
- Latency with sync: 3 cycles (2 synchronizer stages + 1 capture stage).
- Clear latency: `clearData` high before edge N → the flag is 0 after edge N.
- Minimum event spacing: line low for ≥1 sampled cycle between rises. Without sync, a pulse shorter than one cycle that is not present at an edge is missed.
- Reset mid-operation discards all pending and overflow state. There is no partial clear.

## Configuration
- `PENDING_LATCH_SYNC_EN` defined:
  - A 2-flop synchronizer per bit is inserted on `eventData` ahead of edge detection.
  - The synchronizer flops are reset to `DigitSupply[0]`.
  - Capture latency is 3 cycles.
  - Use this when event sources are asynchronous to `Clock`.
- Undefined:
  - `eventData` is used directly.
  - Capture latency is 1 cycle.
  - Sources must be synchronous to `Clock`.

## Test plan
All scenarios use `INPUT_WIDTH`=4, `DigitSupply`=2'b10, sync macro undefined unless noted.
- Reset: assert `Reset` with `eventData`=4'b1111 → both outputs are 4'b0000 asynchronously. After release, first edge → `pendingData`=4'b1111, `overflowData`=4'b0000.
- Single event: `eventData` 4'b0000→4'b0100 → `pendingData`=4'b0100 one cycle later and holds. Pulse `clearData`=4'b0100 for one cycle → `pendingData`=4'b0000.
- Overflow: rise on bit0, drop the line, rise again with no clear → `overflowData`=4'b0001. Then `clearData`=4'b0001 → both outputs bit0=0.
- Set-vs-clear collision: bit1 pending; in the same cycle rise on bit1 and `clearData`=4'b0010 → `pendingData` bit1 stays 1, `overflowData` bit1 stays 0.
- Mask: `maskData`=4'b1000, rise on bit3 → `pendingData` bit3=0. Unmask while the line is still high → bit3 stays 0. Next fresh rise → bit3=1.
- Sync build (`PENDING_LATCH_SYNC_EN` defined): `eventData` bit2 rises before edge N → `pendingData` bit2 is first 1 after edge N+2.

Source files
------------

// File: rtl/_pending_latch.sv
// Sticky per-bit rising-edge capture with mask, clear and overflow flags; feeds the _or reduction.
// Optional feature: define PENDING_LATCH_SYNC_EN to add a 2-flop synchronizer per event line.
module _pending_latch #(
   parameter int INPUT_WIDTH = 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   output logic [INPUT_WIDTH-1:0] pendingData,
   output logic [INPUT_WIDTH-1:0] overflowData,
   input  logic [1:0]             DigitSupply,
   input  logic [INPUT_WIDTH-1:0] eventData,
   input  logic [INPUT_WIDTH-1:0] maskData,
   input  logic [INPUT_WIDTH-1:0] clearData
);

   genvar gi;
   generate
      for (gi = 0; gi < INPUT_WIDTH; gi = gi + 1) begin : g_bit
         logic r_prev;
         logic r_pend;
         logic r_ovf;
         logic w_ev;
         logic w_rise;
         logic w_set;
         logic w_keep;

`ifdef PENDING_LATCH_SYNC_EN
         logic r_sync1;
         logic r_sync2;

         always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
               r_sync1 <= DigitSupply[0];
               r_sync2 <= DigitSupply[0];
            end else begin
               r_sync1 <= eventData[gi];
               r_sync2 <= r_sync1;
            end
         end

         assign w_ev = r_sync2;
`else
         assign w_ev = eventData[gi];
`endif

         // A rise is "line at high level now, previously at low level", levels taken from the supply.
         assign w_rise = (w_ev ~^ DigitSupply[1]) & (r_prev ~^ DigitSupply[0]);
         assign w_set  = w_rise & ~maskData[gi];
         assign w_keep = ~clearData[gi];

         always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
               r_prev <= DigitSupply[0];
               r_pend <= DigitSupply[0];
               r_ovf  <= DigitSupply[0];
            end else begin
               r_prev <= w_ev;
               // A same-cycle set wins over clear so the newer event is never dropped.
               r_pend <= w_set | (r_pend & w_keep);
               r_ovf  <= (w_set & r_pend & w_keep) | (r_ovf & w_keep);
            end
         end

         assign pendingData[gi]  = r_pend;
         assign overflowData[gi] = r_ovf;
      end
   endgenerate

endmodule
